// File: rtl/uart_xmit_arb.sv
// Round-robin arbiter that lets NREQ byte producers share one UART transmitter.
// Drives the xmitH/xmit_dataH/xmit_doneH handshake and acks each winner once its frame has left.
module uart_xmit_arb #(
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              xmitH,
  output logic [7:0]        xmit_dataH,
  input  logic              xmit_doneH,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  localparam int             SW          = IDW + 1;
  localparam logic [7:0]     TIMEOUT_VAL = 8'(BUSY_TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID     = IDW'(NREQ - 1);
  localparam logic [SW-1:0]  NREQ_W      = SW'(NREQ);

  state_t           r_state, w_state_next;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [7:0]       r_cnt, w_cnt_next, w_cnt_inc;
  logic [IDW-1:0]   r_grant_id, w_grant_id_next, w_grant_inc;
  logic [7:0]       r_xmit_data, w_xmit_data_next;
  logic [NREQ-1:0]  r_req_ack, w_req_ack_next;
  logic             r_xmitH, r_busy, r_err_timeout, w_err_timeout_next;

  logic [7:0]       w_req_byte [NREQ];
  logic [2*NREQ-1:0] w_dbl_valid;
  logic [NREQ-1:0]  w_rot_valid;
  logic [SW-1:0]    w_offset, w_sum;
  logic [IDW-1:0]   w_winner;
  logic             w_found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_byte
      assign w_req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Rotate the request vector so rr_ptr lands at bit 0; the lowest set bit is then the winner's offset.
  assign w_dbl_valid = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot_valid = w_dbl_valid[NREQ-1:0];

  always_comb begin
    w_offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) w_offset = SW'(k);
    end
  end

  assign w_found     = |req_valid;
  assign w_sum       = {1'b0, r_rr_ptr} + w_offset;
  assign w_winner    = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : w_sum[IDW-1:0];
  assign w_grant_inc = (r_grant_id == LAST_ID) ? '0 : r_grant_id + IDW'(1);
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    w_rr_ptr_next      = r_rr_ptr;
    w_cnt_next         = r_cnt;
    w_grant_id_next    = r_grant_id;
    w_xmit_data_next   = r_xmit_data;
    w_req_ack_next     = '0;
    w_err_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (xmit_doneH && w_found) begin
          w_state_next     = S_START;
          w_grant_id_next  = w_winner;
          w_xmit_data_next = w_req_byte[w_winner];
        end
      end
      S_START: begin
        w_cnt_next   = '0;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The error pulse fires as the count lands on the limit; the abort follows one cycle later.
        if (r_cnt == TIMEOUT_VAL) begin
          w_state_next  = S_IDLE;
          w_rr_ptr_next = w_grant_inc;
        end else if (!xmit_doneH) begin
          w_state_next = S_WAIT_DONE;
        end else begin
          if (r_cnt != 8'hFF) w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == TIMEOUT_VAL) w_err_timeout_next = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (xmit_doneH) begin
          w_state_next               = S_ACK;
          w_req_ack_next[r_grant_id] = 1'b1;
        end
      end
      S_ACK: begin
        w_rr_ptr_next = w_grant_inc;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_grant_id    <= '0;
      r_xmit_data   <= '0;
      r_req_ack     <= '0;
      r_xmitH       <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rr_ptr      <= w_rr_ptr_next;
      r_cnt         <= w_cnt_next;
      r_grant_id    <= w_grant_id_next;
      r_xmit_data   <= w_xmit_data_next;
      r_req_ack     <= w_req_ack_next;
      r_xmitH       <= (w_state_next == S_START);
      r_busy        <= (w_state_next != S_IDLE);
      r_err_timeout <= w_err_timeout_next;
    end
  end

  assign req_ack     = r_req_ack;
  assign xmitH       = r_xmitH;
  assign xmit_dataH  = r_xmit_data;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_xmit_arb.sv
// Bench for uart_xmit_arb: transmitter model, event monitor and a queue of expected grants
// checked scenario by scenario.
module tb_uart_xmit_arb;

  typedef struct { int id; int data; int cyc; } frame_t;
  typedef struct { int vec; int cyc; } ack_t;
  typedef struct { int id; int data; } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        xmitH;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_rr = 0;

  frame_t obs_f[$];
  ack_t   obs_a[$];
  int     obs_e[$];
  exp_t   exp_q[$];

  // Transmitter model: 0 = normal, 1 = stuck idle (high), 2 = held busy (low)
  int   tx_force = 0;
  int   tx_len = 10;
  logic tx_done = 1'b1;
  int   drop_cnt = 0;
  int   low_cnt = 0;

  assign xmit_doneH = tx_done;

  uart_xmit_arb #(.NREQ(4), .IDW(2), .BUSY_TIMEOUT(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .busy       (busy),
    .grant_id   (grant_id),
    .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (tx_force == 1) begin
      tx_done <= 1'b1;
    end else if (tx_force == 2) begin
      tx_done <= 1'b0;
    end else if (xmitH) begin
      drop_cnt <= 2;
    end else if (drop_cnt != 0) begin
      drop_cnt <= drop_cnt - 1;
      if (drop_cnt == 1) begin
        tx_done <= 1'b0;
        low_cnt <= tx_len;
      end
    end else if (low_cnt != 0) begin
      low_cnt <= low_cnt - 1;
      if (low_cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(negedge sys_clk) begin
    if (xmitH) obs_f.push_back('{int'(grant_id), int'(xmit_dataH), cyc});
    if (req_ack != '0) obs_a.push_back('{int'(req_ack), cyc});
    if (err_timeout) obs_e.push_back(cyc);
  end

  function automatic int rr_pick(input int rr, input logic [3:0] mask);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (rr + k) % 4;
      if (mask[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // A requester drops its valid in the cycle its ack is seen.
  task automatic tick();
    @(negedge sys_clk);
    #1;
    req_valid = req_valid & ~req_ack;
  endtask

  task automatic wait_for(input int nf, input int na, input int ne, input int budget, output bit ok);
    int n;
    n = 0;
    while ((obs_f.size() < nf || obs_a.size() < na || obs_e.size() < ne) && n < budget) begin
      tick();
      n++;
    end
    ok = (obs_f.size() >= nf && obs_a.size() >= na && obs_e.size() >= ne);
  endtask

  task automatic test_reset();
    sys_rst_l = 1'b0;
    repeat (3) tick();
    checks++; if (xmitH !== 1'b0) begin errors++; $display("FAIL rst_xmitH: got %b want 0", xmitH); end
    checks++; if (xmit_dataH !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h want 00", xmit_dataH); end
    checks++; if (req_ack !== 4'h0) begin errors++; $display("FAIL rst_ack: got %b want 0000", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    sys_rst_l = 1'b1;
    m_rr = 0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || obs_f.size() != 0) begin errors++; $display("FAIL idle_after_rst: busy=%b frames=%0d want 0/0", busy, obs_f.size()); end
    $display("test_reset done");
  endtask

  task automatic test_all_four();
    int f0, a0, e0, id;
    logic [3:0] pend;
    bit ok;
    exp_t e;
    f0 = obs_f.size(); a0 = obs_a.size(); e0 = obs_e.size();
    tx_len = 10;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'(17 * (i + 1));
    pend = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      id = rr_pick(m_rr, pend);
      exp_q.push_back('{id, 17 * (id + 1)});
      pend[id[1:0]] = 1'b0;
      m_rr = (id + 1) % 4;
    end
    req_valid = 4'b1111;
    wait_for(f0 + 4, a0 + 4, 0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all4_wait: frames=%0d acks=%0d want 4/4", obs_f.size() - f0, obs_a.size() - a0); return; end
    repeat (4) tick();
    checks++; if (obs_f.size() != f0 + 4) begin errors++; $display("FAIL all4_count: got %0d xmitH want 4", obs_f.size() - f0); end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_f[f0+k].id != e.id || obs_f[f0+k].data != e.data) begin
        errors++; $display("FAIL all4_frame%0d: got id=%0d data=%02h want id=%0d data=%02h", k, obs_f[f0+k].id, obs_f[f0+k].data, e.id, e.data);
      end
      checks++;
      if (obs_a[a0+k].vec != (1 << e.id) || obs_a[a0+k].cyc != obs_f[f0+k].cyc + tx_len + 3) begin
        errors++; $display("FAIL all4_ack%0d: got vec=%0h cyc=%0d want vec=%0h cyc=%0d", k, obs_a[a0+k].vec, obs_a[a0+k].cyc, 1 << e.id, obs_f[f0+k].cyc + tx_len + 3);
      end
      if (k > 0) begin
        checks++;
        if (obs_f[f0+k].cyc != obs_a[a0+k-1].cyc + 2) begin
          errors++; $display("FAIL all4_b2b%0d: xmitH at %0d want %0d", k, obs_f[f0+k].cyc, obs_a[a0+k-1].cyc + 2);
        end
      end
    end
    checks++; if (obs_e.size() != e0) begin errors++; $display("FAIL all4_err: got %0d timeouts want 0", obs_e.size() - e0); end
    $display("test_all_four done");
  endtask

  task automatic test_fairness();
    int f0, a0, seen, n, id, rr;
    exp_t e;
    f0 = obs_f.size(); a0 = obs_a.size();
    req_data[7:0] = 8'hA0;
    req_data[23:16] = 8'hC2;
    rr = m_rr;
    for (int k = 0; k < 4; k++) begin
      id = rr_pick(rr, 4'b0101);
      exp_q.push_back('{id, (id == 0) ? 32'hA0 : 32'hC2});
      rr = (id + 1) % 4;
    end
    m_rr = rr;
    req_valid = 4'b0101;
    seen = a0; n = 0;
    while (obs_a.size() < a0 + 4 && n < 400) begin
      tick();
      n++;
      if (obs_a.size() > seen) begin
        seen = obs_a.size();
        if (seen - a0 <= 2) req_valid = req_valid | 4'(obs_a[seen-1].vec);
      end
    end
    checks++; if (obs_a.size() < a0 + 4) begin errors++; $display("FAIL fair_wait: got %0d acks want 4", obs_a.size() - a0); return; end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_f[f0+k].id != e.id || obs_f[f0+k].data != e.data || obs_a[a0+k].vec != (1 << e.id)) begin
        errors++; $display("FAIL fair_grant%0d: got id=%0d data=%02h ack=%0h want id=%0d data=%02h", k, obs_f[f0+k].id, obs_f[f0+k].data, obs_a[a0+k].vec, e.id, e.data);
      end
    end
    checks++; if (req_valid !== 4'b0000) begin errors++; $display("FAIL fair_drain: req_valid=%b want 0000", req_valid); end
    $display("test_fairness done");
  endtask

  task automatic test_single();
    int f0, a0;
    bit ok;
    exp_t e;
    f0 = obs_f.size(); a0 = obs_a.size();
    tx_len = 160;
    req_data[7:0] = 8'hA5;
    exp_q.push_back('{rr_pick(m_rr, 4'b0001), 32'hA5});
    m_rr = 1;
    req_valid = 4'b0001;
    wait_for(f0 + 1, a0 + 1, 0, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait: frames=%0d acks=%0d want 1/1", obs_f.size() - f0, obs_a.size() - a0); return; end
    e = exp_q.pop_front();
    checks++; if (obs_f[f0].id != e.id || obs_f[f0].data != e.data) begin errors++; $display("FAIL single_frame: got id=%0d data=%02h want id=%0d data=%02h", obs_f[f0].id, obs_f[f0].data, e.id, e.data); end
    checks++; if (obs_a[a0].vec != 1 || obs_a[a0].cyc != obs_f[f0].cyc + 163) begin errors++; $display("FAIL single_ack: got vec=%0h cyc=%0d want vec=1 cyc=%0d", obs_a[a0].vec, obs_a[a0].cyc, obs_f[f0].cyc + 163); end
    tick();
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_width: got %b want 0000", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    checks++; if (xmit_dataH !== 8'hA5 || obs_f.size() != f0 + 1) begin errors++; $display("FAIL single_hold: data=%02h frames=%0d want A5/1", xmit_dataH, obs_f.size() - f0); end
    tx_len = 10;
    $display("test_single done");
  endtask

  task automatic test_timeout();
    int f0, a0, e0, n, id1, id2;
    tx_force = 1;
    tick();
    f0 = obs_f.size(); a0 = obs_a.size(); e0 = obs_e.size();
    req_data[15:8] = 8'h31;
    req_data[23:16] = 8'h32;
    id1 = rr_pick(m_rr, 4'b0110);
    id2 = rr_pick((id1 + 1) % 4, 4'b0110);
    m_rr = (id2 + 1) % 4;
    exp_q.push_back('{id1, 32'h30 + id1});
    exp_q.push_back('{id2, 32'h30 + id2});
    req_valid = 4'b0110;
    n = 0;
    while (obs_e.size() < e0 + 2 && n < 60) begin
      tick();
      n++;
    end
    req_valid = 4'b0000;
    checks++; if (obs_e.size() < e0 + 2) begin errors++; $display("FAIL tmo_wait: got %0d timeouts want 2", obs_e.size() - e0); tx_force = 0; return; end
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_f[f0+k].id != e.id || obs_f[f0+k].data != e.data) begin
        errors++; $display("FAIL tmo_frame%0d: got id=%0d data=%02h want id=%0d data=%02h", k, obs_f[f0+k].id, obs_f[f0+k].data, e.id, e.data);
      end
      checks++;
      if (obs_e[e0+k] != obs_f[f0+k].cyc + 5) begin
        errors++; $display("FAIL tmo_latency%0d: err at %0d want %0d", k, obs_e[e0+k], obs_f[f0+k].cyc + 5);
      end
    end
    checks++; if (obs_e.size() != e0 + 2 || obs_f.size() != f0 + 2) begin errors++; $display("FAIL tmo_count: errs=%0d frames=%0d want 2/2", obs_e.size() - e0, obs_f.size() - f0); end
    checks++; if (obs_a.size() != a0) begin errors++; $display("FAIL tmo_noack: got %0d acks want 0", obs_a.size() - a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
    tx_force = 0;
    $display("test_timeout done");
  endtask

  task automatic test_idle_hold();
    int f0, a0, rise;
    bit ok;
    exp_t e;
    tx_force = 2;
    tick();
    f0 = obs_f.size(); a0 = obs_a.size();
    req_data[31:24] = 8'h5A;
    exp_q.push_back('{rr_pick(m_rr, 4'b1000), 32'h5A});
    m_rr = 0;
    req_valid = 4'b1000;
    repeat (10) tick();
    checks++; if (obs_f.size() != f0 || busy !== 1'b0) begin errors++; $display("FAIL hold_nogrant: frames=%0d busy=%b want 0/0", obs_f.size() - f0, busy); end
    tx_force = 1;
    tick();
    rise = cyc;
    tx_force = 0;
    wait_for(f0 + 1, a0 + 1, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_wait: frames=%0d acks=%0d want 1/1", obs_f.size() - f0, obs_a.size() - a0); return; end
    e = exp_q.pop_front();
    checks++; if (obs_f[f0].cyc != rise + 1) begin errors++; $display("FAIL hold_latency: xmitH at %0d want %0d", obs_f[f0].cyc, rise + 1); end
    checks++; if (obs_f[f0].id != e.id || obs_f[f0].data != e.data || obs_a[a0].vec != (1 << e.id)) begin errors++; $display("FAIL hold_frame: got id=%0d data=%02h ack=%0h want id=%0d data=%02h", obs_f[f0].id, obs_f[f0].data, obs_a[a0].vec, e.id, e.data); end
    $display("test_idle_hold done");
  endtask

  task automatic test_reset_abort();
    int f0, a0, id;
    bit ok;
    exp_t e;
    f0 = obs_f.size(); a0 = obs_a.size();
    req_data[15:8] = 8'h77;
    exp_q.push_back('{rr_pick(m_rr, 4'b0010), 32'h77});
    m_rr = 2;
    req_valid = 4'b0010;
    wait_for(f0 + 1, a0 + 1, 0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_warm_wait: no ack"); return; end
    e = exp_q.pop_front();
    checks++; if (obs_f[f0].id != e.id || obs_f[f0].data != e.data) begin errors++; $display("FAIL abort_warm: got id=%0d data=%02h want id=%0d data=%02h", obs_f[f0].id, obs_f[f0].data, e.id, e.data); end
    tick();
    req_data[15:8] = 8'h99;
    req_data[31:24] = 8'h88;
    id = rr_pick(m_rr, 4'b1010);
    exp_q.push_back('{id, (id == 3) ? 32'h88 : 32'h99});
    req_valid = 4'b1010;
    wait_for(f0 + 2, 0, 0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_grant_wait: no xmitH"); return; end
    e = exp_q.pop_front();
    checks++; if (obs_f[f0+1].id != e.id || obs_f[f0+1].data != e.data) begin errors++; $display("FAIL abort_pre: got id=%0d data=%02h want id=%0d data=%02h", obs_f[f0+1].id, obs_f[f0+1].data, e.id, e.data); end
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || xmit_doneH !== 1'b0) begin errors++; $display("FAIL abort_in_wait_done: busy=%b done=%b want 1/0", busy, xmit_doneH); end
    sys_rst_l = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || xmitH !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL abort_rst_ctl: busy=%b xmitH=%b err=%b want 000", busy, xmitH, err_timeout); end
    checks++; if (xmit_dataH !== 8'h00 || grant_id !== 2'd0 || req_ack !== 4'h0) begin errors++; $display("FAIL abort_rst_data: data=%02h id=%0d ack=%b want 00/0/0000", xmit_dataH, grant_id, req_ack); end
    repeat (2) tick();
    sys_rst_l = 1'b1;
    m_rr = 0;
    a0 = obs_a.size();
    for (int k = 0; k < 2; k++) begin
      id = rr_pick(m_rr, (k == 0) ? 4'b1010 : 4'b1000);
      exp_q.push_back('{id, (id == 3) ? 32'h88 : 32'h99});
      m_rr = (id + 1) % 4;
    end
    wait_for(f0 + 4, a0 + 2, 0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_post_wait: frames=%0d acks=%0d want 2/2", obs_f.size() - f0 - 2, obs_a.size() - a0); return; end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_f[f0+2+k].id != e.id || obs_f[f0+2+k].data != e.data || obs_a[a0+k].vec != (1 << e.id)) begin
        errors++; $display("FAIL abort_post%0d: got id=%0d data=%02h ack=%0h want id=%0d data=%02h", k, obs_f[f0+2+k].id, obs_f[f0+2+k].data, obs_a[a0+k].vec, e.id, e.data);
      end
    end
    repeat (3) tick();
    checks++; if (obs_a.size() != a0 + 2) begin errors++; $display("FAIL abort_ack_count: got %0d acks want 2", obs_a.size() - a0); end
    $display("test_reset_abort done");
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_fairness();
    test_single();
    test_timeout();
    test_idle_hold();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_xmit_arb.md
# uart_xmit_arb

Round-robin arbiter that lets NREQ requesters share the single UART transmitter.
- Accepts one byte per requester through a valid/ack handshake.
- Sequences the transmitter's xmitH/xmit_doneH handshake and returns a one-cycle ack to the winner when its frame has left the line.
- Sits between the system-side byte producers and the transmitter's xmitH/xmit_dataH/xmit_doneH port.

## Interface
Parameters:
- NREQ, 4: number of requesters, range 2..8.
- IDW, 2: width of grant_id; equals ceil(log2(NREQ)).
- BUSY_TIMEOUT, 4: cycles to wait for xmit_doneH to fall after the xmitH pulse, range 1..255.

Ports:
- sys_clk  in  1  clock.
- sys_rst_l  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i high: requester i has a byte pending.
- req_data  in  8*NREQ  byte i occupies bits [8i+7:8i].
- req_ack  out  NREQ  one-cycle pulse on bit i when requester i's byte has been transmitted.
- xmitH  out  1  one-cycle start pulse to the transmitter.
- xmit_dataH  out  8  byte to the transmitter.
- xmit_doneH  in  1  transmitter idle/done level; high when the transmitter is idle.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  IDW  index of the current or last granted requester.
- err_timeout  out  1  one-cycle pulse when the transmitter did not accept the start pulse.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, ACK. Reset state is IDLE.
- All outputs are registered.

IDLE
- Grant only when xmit_doneH=1 and req_valid is nonzero.
- Winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
- On grant: latch req_data slice i into xmit_dataH, set grant_id=i, go to START.
- If xmit_doneH=0, stay in IDLE regardless of req_valid.

START
- xmitH=1 for exactly this one cycle.
- Clear the timeout counter and go to WAIT_BUSY.

WAIT_BUSY
- If xmit_doneH=0: go to WAIT_DONE.
- Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse err_timeout and go to IDLE.
  - No ack is issued.
  - rr_ptr is set to grant_id+1, so the failed requester is retried only after the others.

WAIT_DONE
- Hold until xmit_doneH=1, then go to ACK.
- No timeout; frame length is owned by the transmitter.

ACK
- req_ack[grant_id]=1 for one cycle.
- Set rr_ptr=(grant_id+1) mod NREQ, then go to IDLE.

Common rules
- xmit_dataH stays stable from the grant until the next grant.
- Requester rule: hold req_valid and req_data from assertion until the req_ack pulse.
  - If req_valid drops after the grant, the transfer still completes and the ack is still pulsed.
  - Changes to req_data after the grant are ignored.
- Requesters asserting req_valid in the same cycle are resolved by rr_ptr alone; there is no fixed priority.
- rr_ptr wraps from NREQ-1 to 0.
- The counter is 8 bits and saturates; it never wraps.

## Timing
Reset values, all asynchronous:
- xmitH=0, xmit_dataH=0, req_ack=0, busy=0, grant_id=0, err_timeout=0.
- rr_ptr=0, state=IDLE, counter=0.

Cycle-level behaviour:
- Grant latency: IDLE samples a request at edge N; xmitH and busy are high in cycle N+1; xmit_dataH is valid from N+1.
- xmit_doneH is sampled in WAIT_BUSY from cycle N+2.
- Ack timing: xmit_doneH is sampled high in WAIT_DONE at edge M; req_ack is high in cycle M+1; busy is low from M+2.
- Back-to-back: the next grant can be sampled at the first IDLE edge, so the next xmitH comes no earlier than 2 cycles after req_ack.
- Timeout: err_timeout is high in the cycle after the counter reaches BUSY_TIMEOUT; busy is low in the following cycle.
- Reset asserted mid-operation:
  - Immediate abort; all outputs return to reset values.
  - No ack is issued; pending requests are re-arbitrated from rr_ptr=0 after release.

## Test plan
- Single request, req_valid=0001, data 8'hA5, transmitter model drops xmit_doneH 2 cycles after xmitH and raises it 160 cycles later -> one xmitH pulse, xmit_dataH=A5, req_ack=0001 one cycle, busy low afterwards.
- All four requesters asserted at once, data 11/22/33/44 -> frames sent in order 0,1,2,3; each req_ack pulse follows its frame; exactly 4 xmitH pulses.
- Fairness: req0 is re-asserted immediately after every ack while req2 stays pending -> grants alternate 0,2,0,2; req2 never waits more than one frame.
- xmit_doneH held high (stuck transmitter) with BUSY_TIMEOUT=4 -> err_timeout pulse 5 cycles after xmitH, no req_ack, next grant goes to the next pending index.
- xmit_doneH=0 while in IDLE with req_valid=1000 -> no xmitH until xmit_doneH rises; the grant follows within 1 cycle of the rise.
- sys_rst_l pulsed low during WAIT_DONE -> all outputs 0 immediately, no ack; after release the pending request is re-granted starting from index 0.
